// File: rtl/seq_alu.sv
// seq_alu: multi-cycle integer ALU for the v68k execute stage.
//
// Single-cycle ops (ADD, ADDX, SUB, SUBX, AND, OR, EOR, NOP and DIVU by zero)
// finish on the accepting edge. MULU (shift-add) and DIVU (restoring) take
// BITS further edges and produce a double-width result.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   start, op, a, b  request; sampled only while busy = 0
//   o, o_hi          result low/high half (MULU product, DIVU quotient/remainder)
//   c, z, v, n, x    registered condition flags (x is the 68000 extend flag)
//   dz               DIVU attempted with b = 0; cleared by the next accepted op
//   busy             MULU/DIVU iteration in progress
//   done             one-cycle pulse on the edge that updates results/flags
module seq_alu #(
  parameter int unsigned BITS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] o,
  output logic [BITS-1:0] o_hi,
  output logic            c,
  output logic            z,
  output logic            v,
  output logic            n,
  output logic            x,
  output logic            dz,
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDX = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBX = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_EOR  = 4'd6;
  localparam logic [3:0] OP_MULU = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;

  localparam int unsigned CW = $clog2(BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);
  localparam int unsigned MSB = BITS - 1;

  // State
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Multiplicand (MULU) or divisor (DIVU), held for the whole iteration.
  logic [BITS-1:0]   opnd_q, opnd_d;
  // MULU: {partial high, remaining multiplier}. DIVU: {remainder, dividend/quotient}.
  logic [2*BITS-1:0] acc_q, acc_d;

  logic [BITS-1:0]   o_q, o_d;
  logic [BITS-1:0]   o_hi_q, o_hi_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic              v_q, v_d;
  logic              n_q, n_d;
  logic              x_q, x_d;
  logic              dz_q, dz_d;
  logic              done_q, done_d;

  // Single-cycle arithmetic, straight from the input operands.
  logic              xin;
  logic [BITS:0]     add_sum;
  logic [BITS:0]     sub_diff;
  logic              add_v;
  logic              sub_v;

  always_comb begin
    xin      = ((op == OP_ADDX) || (op == OP_SUBX)) ? x_q : 1'b0;
    add_sum  = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, xin};
    // Bit BITS of the difference is the borrow out of a - b - xin.
    sub_diff = {1'b0, a} - {1'b0, b} - {{BITS{1'b0}}, xin};
    add_v    = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
    sub_v    = (a[MSB] != b[MSB]) && (sub_diff[MSB] != a[MSB]);
  end

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  logic [BITS:0]     mul_sum;
  logic [2*BITS-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*BITS-1:BITS]} + (acc_q[0] ? {1'b0, opnd_q} : {(BITS+1){1'b0}});
    mul_next = {mul_sum, acc_q[BITS-1:1]};
  end

  // One restoring-division step. The remainder is always below the divisor,
  // so when the trial subtraction succeeds the result fits in BITS bits and
  // the modulo-2^BITS subtraction below is exact.
  logic [BITS:0]     rem_sh;
  logic              div_ge;
  logic [BITS-1:0]   rem_new;
  logic [2*BITS-1:0] div_next;

  always_comb begin
    rem_sh   = {acc_q[2*BITS-1:BITS], acc_q[BITS-1]};
    div_ge   = (rem_sh >= {1'b0, opnd_q});
    rem_new  = div_ge ? (rem_sh[BITS-1:0] - opnd_q) : rem_sh[BITS-1:0];
    div_next = {rem_new, acc_q[BITS-2:0], div_ge};
  end

  // Next-state logic
  logic [BITS-1:0] log_res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    o_d     = o_q;
    o_hi_d  = o_hi_q;
    c_d     = c_q;
    z_d     = z_q;
    v_d     = v_q;
    n_d     = n_q;
    x_d     = x_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    log_res = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dz_d = 1'b0;
          unique case (op)
            OP_ADD, OP_ADDX: begin
              o_d    = add_sum[BITS-1:0];
              o_hi_d = '0;
              c_d    = add_sum[BITS];
              x_d    = add_sum[BITS];
              v_d    = add_v;
              n_d    = add_sum[MSB];
              // ADDX keeps z sticky so multi-precision chains test the whole value.
              z_d    = (op == OP_ADDX) ? (z_q && (add_sum[BITS-1:0] == '0))
                                       : (add_sum[BITS-1:0] == '0);
              done_d = 1'b1;
            end
            OP_SUB, OP_SUBX: begin
              o_d    = sub_diff[BITS-1:0];
              o_hi_d = '0;
              c_d    = sub_diff[BITS];
              x_d    = sub_diff[BITS];
              v_d    = sub_v;
              n_d    = sub_diff[MSB];
              z_d    = (op == OP_SUBX) ? (z_q && (sub_diff[BITS-1:0] == '0))
                                       : (sub_diff[BITS-1:0] == '0);
              done_d = 1'b1;
            end
            OP_AND, OP_OR, OP_EOR: begin
              if (op == OP_AND) begin
                log_res = a & b;
              end else if (op == OP_OR) begin
                log_res = a | b;
              end else begin
                log_res = a ^ b;
              end
              o_d    = log_res;
              o_hi_d = '0;
              c_d    = 1'b0;
              v_d    = 1'b0;
              z_d    = (log_res == '0);
              n_d    = log_res[MSB];
              done_d = 1'b1;
            end
            OP_MULU: begin
              state_d = MUL;
              cnt_d   = '0;
              opnd_d  = a;
              acc_d   = {{BITS{1'b0}}, b};
            end
            OP_DIVU: begin
              if (b == '0) begin
                // Divide by zero: flag it and leave the result registers alone.
                dz_d   = 1'b1;
                c_d    = 1'b0;
                v_d    = 1'b0;
                done_d = 1'b1;
              end else begin
                state_d = DIV;
                cnt_d   = '0;
                opnd_d  = b;
                acc_d   = {{BITS{1'b0}}, a};
              end
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end

      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          o_d     = mul_next[BITS-1:0];
          o_hi_d  = mul_next[2*BITS-1:BITS];
          z_d     = (mul_next == '0);
          n_d     = mul_next[2*BITS-1];
          c_d     = 1'b0;
          v_d     = 1'b0;
          done_d  = 1'b1;
        end
      end

      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          o_d     = div_next[BITS-1:0];
          o_hi_d  = div_next[2*BITS-1:BITS];
          z_d     = (div_next[BITS-1:0] == '0);
          n_d     = div_next[MSB];
          c_d     = 1'b0;
          v_d     = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      o_q     <= '0;
      o_hi_q  <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      x_q     <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      o_q     <= o_d;
      o_hi_q  <= o_hi_d;
      c_q     <= c_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
      x_q     <= x_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign o    = o_q;
  assign o_hi = o_hi_q;
  assign c    = c_q;
  assign z    = z_q;
  assign v    = v_q;
  assign n    = n_q;
  assign x    = x_q;
  assign dz   = dz_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios followed by random
// operations, all compared against an arithmetic reference model.
module tb_seq_alu;
  parameter int BITS = 16;

  localparam logic [63:0] MASK    = (64'd1 << BITS) - 64'd1;
  localparam logic [63:0] MSB_VAL = 64'd1 << (BITS - 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [3:0]      op;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic [BITS-1:0] o;
  logic [BITS-1:0] o_hi;
  logic            c, z, v, n, x, dz, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [63:0] m_o, m_hi;
  bit          m_c, m_z, m_v, m_n, m_x, m_dz;

  always #5 clk = ~clk;

  seq_alu #(.BITS(BITS)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .o    (o),
    .o_hi (o_hi),
    .c    (c),
    .z    (z),
    .v    (v),
    .n    (n),
    .x    (x),
    .dz   (dz),
    .busy (busy),
    .done (done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint to_signed(input logic [63:0] val);
    if (((val >> (BITS - 1)) & 64'd1) != 0) return longint'(val) - (longint'(1) << BITS);
    return longint'(val);
  endfunction

  function automatic bit out_of_range(input longint r);
    longint lim;
    lim = longint'(1) << (BITS - 1);
    return (r > lim - 1) || (r < -lim);
  endfunction

  task automatic model_reset();
    m_o = 0; m_hi = 0;
    m_c = 0; m_z = 0; m_v = 0; m_n = 0; m_x = 0; m_dz = 0;
  endtask

  // Architectural effect of one accepted operation.
  task automatic model_apply(input logic [3:0] op_v, input logic [63:0] a_in,
                             input logic [63:0] b_in);
    logic [63:0] av, bv, res, prod;
    longint      xin, ur, sr;
    av = a_in & MASK;
    bv = b_in & MASK;
    m_dz = 0;
    case (op_v)
      4'd0, 4'd1: begin
        xin = (op_v == 4'd1) ? longint'(m_x) : 0;
        ur  = longint'(av) + longint'(bv) + xin;
        sr  = to_signed(av) + to_signed(bv) + xin;
        res = 64'(ur) & MASK;
        m_c = ur > longint'(MASK);
        m_x = m_c;
        m_v = out_of_range(sr);
        m_z = (op_v == 4'd1) ? (m_z && res == 0) : (res == 0);
        m_n = (res & MSB_VAL) != 0;
        m_o = res; m_hi = 0;
      end
      4'd2, 4'd3: begin
        xin = (op_v == 4'd3) ? longint'(m_x) : 0;
        ur  = longint'(av) - longint'(bv) - xin;
        sr  = to_signed(av) - to_signed(bv) - xin;
        res = 64'(ur) & MASK;
        m_c = ur < 0;
        m_x = m_c;
        m_v = out_of_range(sr);
        m_z = (op_v == 4'd3) ? (m_z && res == 0) : (res == 0);
        m_n = (res & MSB_VAL) != 0;
        m_o = res; m_hi = 0;
      end
      4'd4, 4'd5, 4'd6: begin
        res = (op_v == 4'd4) ? (av & bv) : (op_v == 4'd5) ? (av | bv) : (av ^ bv);
        m_c = 0; m_v = 0;
        m_z = res == 0;
        m_n = (res & MSB_VAL) != 0;
        m_o = res; m_hi = 0;
      end
      4'd7: begin
        prod = av * bv;
        m_o  = prod & MASK;
        m_hi = (prod >> BITS) & MASK;
        m_z  = prod == 0;
        m_n  = (m_hi & MSB_VAL) != 0;
        m_c  = 0; m_v = 0;
      end
      4'd8: begin
        m_c = 0; m_v = 0;
        if (bv == 0) begin
          m_dz = 1;
        end else begin
          m_o  = av / bv;
          m_hi = av % bv;
          m_z  = m_o == 0;
          m_n  = (m_o & MSB_VAL) != 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".o"},    64'(o),    m_o);
    check_eq({tag, ".o_hi"}, 64'(o_hi), m_hi);
    check_eq({tag, ".c"},    64'(c),    64'(m_c));
    check_eq({tag, ".z"},    64'(z),    64'(m_z));
    check_eq({tag, ".v"},    64'(v),    64'(m_v));
    check_eq({tag, ".n"},    64'(n),    64'(m_n));
    check_eq({tag, ".x"},    64'(x),    64'(m_x));
    check_eq({tag, ".dz"},   64'(dz),   64'(m_dz));
  endtask

  // Called #1 after a rising edge; issues one op and waits for its done.
  // While busy, inputs are scrambled and a stray ADD start is pulsed; both
  // must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op_v, input logic [63:0] a_v,
                        input logic [63:0] b_v);
    int edges, busy_cnt, lat_exp;
    bit multi;
    multi   = (op_v == 4'd7) || ((op_v == 4'd8) && ((b_v & MASK) != 0));
    lat_exp = multi ? BITS : 0;
    start = 1'b1;
    op    = op_v;
    a     = BITS'(a_v & MASK);
    b     = BITS'(b_v & MASK);
    @(posedge clk);
    model_apply(op_v, a_v, b_v);
    #1;
    start    = 1'b0;
    edges    = 0;
    busy_cnt = 0;
    while (!done && edges < BITS + 4) begin
      if (busy) busy_cnt++;
      a  = BITS'($urandom);
      b  = BITS'($urandom);
      op = 4'($urandom);
      if (edges == 2) begin
        start = 1'b1;
        op    = 4'd0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      edges++;
    end
    check_eq({tag, ".latency"}, 64'(edges), 64'(lat_exp));
    check_eq({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(lat_exp));
    check_eq({tag, ".done"}, 64'(done), 64'd1);
    check_eq({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    check_all(tag);
  endtask

  // One cycle without start: done must have been a single pulse.
  task automatic idle_cycle(input string tag);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, ".done_pulse"}, 64'(done), 64'd0);
    check_eq({tag, ".busy_idle"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 64'd0;
      1:       return MASK;
      2:       return MSB_VAL;
      3:       return 64'($urandom_range(0, 7));
      default: return {$urandom, $urandom} & MASK;
    endcase
  endfunction

  initial begin
    logic [3:0]  rop;
    logic [63:0] ra, rb;

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    check_eq("reset.busy", 64'(busy), 64'd0);
    check_eq("reset.done", 64'(done), 64'd0);
    reset = 1'b0;

    // Some non-zero state first so that the mid-MULU reset is observable.
    run_op("pre_add", 4'd0, MASK, 64'd3);

    // Reset three cycles into a MULU.
    start = 1'b1;
    op    = 4'd7;
    a     = BITS'(MASK);
    b     = BITS'(MASK);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("mid_mulu.busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("mid_reset");
    check_eq("mid_reset.busy", 64'(busy), 64'd0);
    check_eq("mid_reset.done", 64'(done), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("after_reset.done", 64'(done), 64'd0);

    run_op("rst_add", 4'd0, 64'd0, 64'd0);
    check_eq("rst_add.z_exp", 64'(z), 64'd1);

    // Add/sub flag behaviour, including sticky z for the extended forms.
    run_op("add_ovf", 4'd0, MASK >> 1, 64'd1);
    check_eq("add_ovf.o_exp", 64'(o), MSB_VAL);
    check_eq("add_ovf.v_exp", 64'(v), 64'd1);
    run_op("add_carry", 4'd0, MASK, 64'd1);
    check_eq("add_carry.x_exp", 64'(x), 64'd1);
    run_op("addx", 4'd1, 64'd0, 64'd0);
    check_eq("addx.o_exp", 64'(o), 64'd1);
    run_op("sub_zero", 4'd2, 64'd0, 64'd0);
    run_op("subx_sticky", 4'd3, 64'd5, 64'd5);
    check_eq("subx_sticky.z_exp", 64'(z), 64'd1);
    run_op("sub_borrow", 4'd2, 64'd0, 64'd1);
    check_eq("sub_borrow.o_exp", 64'(o), MASK);
    idle_cycle("pre_mulu");

    // Largest product; x must survive from the borrow above.
    run_op("mulu_max", 4'd7, MASK, MASK);
    check_eq("mulu_max.hi_exp", 64'(o_hi), MASK - 64'd1);
    check_eq("mulu_max.lo_exp", 64'(o), 64'd1);
    check_eq("mulu_max.x_kept", 64'(x), 64'd1);
    idle_cycle("mulu_single_done");

    run_op("divu", 4'd8, 64'd7, 64'd2);
    check_eq("divu.q_exp", 64'(o), 64'd3);
    check_eq("divu.r_exp", 64'(o_hi), 64'd1);
    run_op("divu_zero", 4'd8, 64'h1234 & MASK, 64'd0);
    check_eq("divu_zero.o_kept", 64'(o), 64'd3);
    check_eq("divu_zero.dz_exp", 64'(dz), 64'd1);
    run_op("nop", 4'd9, 64'd1, 64'd1);

    // Back-to-back: the ADD is issued in the done cycle of the MULU.
    run_op("b2b_mulu", 4'd7, 64'($urandom) & MASK, 64'($urandom) & MASK);
    run_op("b2b_add", 4'd0, 64'd2, 64'd3);
    run_op("b2b_divu", 4'd8, MASK, 64'd3);
    run_op("b2b_sub", 4'd2, 64'd1, 64'd1);

    for (int i = 0; i < 300; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
      if ($urandom_range(0, 3) == 0) idle_cycle($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
